// File: rtl/i2d_core_defines.sv
// Shared i2d core front-end types: PC select, exception cause, hazard FSM states.
// Register-file and address widths live here so decode, IF and the hazard unit agree.
package i2d_core_defines;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned ADDR_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [ADDR_W-1:0]     addr_t;

    // PC lives in the register file; a load to it is a jump, never a data hazard.
    localparam reg_addr_t RF_PC           = 4'd15;
    localparam addr_t     EXC_VECTOR_ADDR = 32'h0000_0008;

    typedef enum logic [1:0] {
        PcSeq,
        PcBranch,
        PcVector,
        PcEpc
    } pc_sel_t;

    typedef enum logic [1:0] {
        ExcNone,
        ExcSwi,
        ExcErr,
        ExcIrq
    } exc_cause_t;

    typedef enum logic [2:0] {
        StRun,
        StLoadStall,
        StMemStall,
        StExcFlush,
        StExcVector
    } hzd_state_t;

endpackage

// File: rtl/core_hazard_detect.sv
// Combinational load-use comparator between the EX-stage load and the decode sources.
module core_hazard_detect
    import i2d_core_defines::*;
(
    input  logic      ex_load,
    input  reg_addr_t ex_regd,
    input  reg_addr_t id_rega_addr,
    input  reg_addr_t id_regb_addr,
    input  logic      id_uses_regb,
    output logic      load_use
);

    assign load_use = ex_load && (ex_regd != RF_PC) &&
                      ((ex_regd == id_rega_addr) ||
                       (id_uses_regb && (ex_regd == id_regb_addr)));

endmodule

// File: rtl/core_hazard_ctrl.sv
// Front-end sequencing: stage halts/flushes, exception entry/return, next-PC select.
// Define I2D_HAZARD_IRQ_EN to add the external irq input.
module core_hazard_ctrl
    import i2d_core_defines::*;
#(
    parameter int unsigned LOAD_USE_CYCLES  = 1,
    parameter int unsigned EXC_FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_addr_t  id_rega_addr,
    input  reg_addr_t  id_regb_addr,
    input  logic       id_uses_regb,
    input  logic       ex_load,
    input  reg_addr_t  ex_regd,
    input  logic       mau_busy,
    input  logic       ex_branch,
    input  logic       swi,
    input  logic       rfe,
    input  logic       id_err,
`ifdef I2D_HAZARD_IRQ_EN
    input  logic       irq,
`endif
    input  addr_t      id_pc,
    output logic       if_halt,
    output logic       id_halt,
    output logic       id_flush,
    output logic       ex_flush,
    output pc_sel_t    pc_sel,
    output addr_t      epc,
    output exc_cause_t exc_cause,
    output logic       in_exc
);

    localparam logic [2:0] LoadStallCnt =
        3'((LOAD_USE_CYCLES > 1) ? (LOAD_USE_CYCLES - 2) : 0);
    localparam logic [2:0] ExcFlushCnt = 3'(EXC_FLUSH_CYCLES - 1);

    hzd_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    addr_t      epc_q, epc_d;
    exc_cause_t cause_q, cause_d;
    logic       in_exc_q, in_exc_d;

    logic       if_halt_c, id_halt_c, id_flush_c, ex_flush_c;
    pc_sel_t    pc_sel_c;
    logic       load_use;
    logic       irq_take;
    logic       exc_take;
    exc_cause_t exc_code;

    core_hazard_detect u_detect (
        .ex_load      (ex_load),
        .ex_regd      (ex_regd),
        .id_rega_addr (id_rega_addr),
        .id_regb_addr (id_regb_addr),
        .id_uses_regb (id_uses_regb),
        .load_use     (load_use)
    );

`ifdef I2D_HAZARD_IRQ_EN
    // Interrupts are masked while a handler is running.
    assign irq_take = irq && !in_exc_q;
`else
    assign irq_take = 1'b0;
`endif

    assign exc_take = id_err || swi || irq_take;
    assign exc_code = id_err ? ExcErr : (swi ? ExcSwi : ExcIrq);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        in_exc_d   = in_exc_q;
        if_halt_c  = 1'b0;
        id_halt_c  = 1'b0;
        id_flush_c = 1'b0;
        ex_flush_c = 1'b0;
        pc_sel_c   = PcSeq;

        unique case (state_q)
            StRun: begin
                if (mau_busy) begin
                    if_halt_c = 1'b1;
                    id_halt_c = 1'b1;
                    state_d   = StMemStall;
                end else if (exc_take) begin
                    if_halt_c  = 1'b1;
                    id_flush_c = 1'b1;
                    ex_flush_c = 1'b1;
                    epc_d      = id_pc;
                    cause_d    = exc_code;
                    in_exc_d   = 1'b1;
                    cnt_d      = ExcFlushCnt;
                    state_d    = (ExcFlushCnt != 3'd0) ? StExcFlush : StExcVector;
                end else if (ex_branch) begin
                    pc_sel_c   = PcBranch;
                    id_flush_c = 1'b1;
                end else if (load_use) begin
                    if_halt_c  = 1'b1;
                    id_halt_c  = 1'b1;
                    ex_flush_c = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        state_d = StLoadStall;
                        cnt_d   = LoadStallCnt;
                    end
                end else if (rfe) begin
                    pc_sel_c   = PcEpc;
                    id_flush_c = 1'b1;
                    in_exc_d   = 1'b0;
                    cause_d    = ExcNone;
                end
            end
            StLoadStall: begin
                if_halt_c  = 1'b1;
                id_halt_c  = 1'b1;
                ex_flush_c = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StMemStall: begin
                if_halt_c = mau_busy;
                id_halt_c = mau_busy;
                if (!mau_busy) begin
                    state_d = StRun;
                end
            end
            StExcFlush: begin
                if_halt_c  = 1'b1;
                id_flush_c = 1'b1;
                // Leave on the last flush cycle so entry-to-vector spans EXC_FLUSH_CYCLES.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = StExcVector;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StExcVector: begin
                pc_sel_c   = PcVector;
                id_flush_c = 1'b1;
                state_d    = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            cnt_q    <= 3'd0;
            epc_q    <= '0;
            cause_q  <= ExcNone;
            in_exc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            in_exc_q <= in_exc_d;
        end
    end

    // Reset forces every output quiet in the same cycle, not just after the edge.
    assign if_halt   = !rst && if_halt_c;
    assign id_halt   = !rst && id_halt_c;
    assign id_flush  = !rst && id_flush_c;
    assign ex_flush  = !rst && ex_flush_c;
    assign pc_sel    = rst ? PcSeq : pc_sel_c;
    assign epc       = rst ? '0 : epc_q;
    assign exc_cause = rst ? ExcNone : cause_q;
    assign in_exc    = !rst && in_exc_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Bench for core_hazard_ctrl: directed vector table, corner sequences and random
// stimulus against a cycle-count reference model, on two parameterisations.
`timescale 1ns/1ps
module tb_core_hazard_ctrl;
    import i2d_core_defines::*;

`ifdef I2D_HAZARD_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    typedef struct packed {
        logic      rst, mau_busy, ex_branch, ex_load;
        reg_addr_t ex_regd, rega, regb;
        logic      uses_regb, swi, rfe, id_err, irq;
        addr_t     id_pc;
    } stim_t;

    typedef struct packed {
        logic       if_halt, id_halt, id_flush, ex_flush;
        pc_sel_t    pc_sel;
        addr_t      epc;
        exc_cause_t cause;
        logic       in_exc;
    } obs_t;

    typedef struct { stim_t s; obs_t e; } vec_t;

    // Model state: remaining stall/flush cycles rather than FSM states.
    typedef struct {
        bit mem; int stall_left; int flush_left; bit vec;
        addr_t epc; exc_cause_t cause; bit in_exc;
    } mstate_t;

    logic clk = 1'b0;
    logic rst, id_uses_regb, ex_load, mau_busy, ex_branch, swi, rfe, id_err;
    reg_addr_t id_rega_addr, id_regb_addr, ex_regd;
    addr_t id_pc;
`ifdef I2D_HAZARD_IRQ_EN
    logic irq;
`endif

    logic if_halt1, id_halt1, id_flush1, ex_flush1, in_exc1;
    logic if_halt3, id_halt3, id_flush3, ex_flush3, in_exc3;
    pc_sel_t pc_sel1, pc_sel3;
    addr_t epc1, epc3;
    exc_cause_t cause1, cause3;
    obs_t o1, o3;

    int n_checks = 0;
    int n_fail = 0;
    mstate_t m1, m3;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign o1 = {if_halt1, id_halt1, id_flush1, ex_flush1, pc_sel1, epc1, cause1, in_exc1};
    assign o3 = {if_halt3, id_halt3, id_flush3, ex_flush3, pc_sel3, epc3, cause3, in_exc3};

    core_hazard_ctrl #(.LOAD_USE_CYCLES(1), .EXC_FLUSH_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .id_rega_addr(id_rega_addr), .id_regb_addr(id_regb_addr),
        .id_uses_regb(id_uses_regb), .ex_load(ex_load), .ex_regd(ex_regd),
        .mau_busy(mau_busy), .ex_branch(ex_branch), .swi(swi), .rfe(rfe), .id_err(id_err),
`ifdef I2D_HAZARD_IRQ_EN
        .irq(irq),
`endif
        .id_pc(id_pc), .if_halt(if_halt1), .id_halt(id_halt1), .id_flush(id_flush1),
        .ex_flush(ex_flush1), .pc_sel(pc_sel1), .epc(epc1), .exc_cause(cause1),
        .in_exc(in_exc1)
    );

    core_hazard_ctrl #(.LOAD_USE_CYCLES(3), .EXC_FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_rega_addr(id_rega_addr), .id_regb_addr(id_regb_addr),
        .id_uses_regb(id_uses_regb), .ex_load(ex_load), .ex_regd(ex_regd),
        .mau_busy(mau_busy), .ex_branch(ex_branch), .swi(swi), .rfe(rfe), .id_err(id_err),
`ifdef I2D_HAZARD_IRQ_EN
        .irq(irq),
`endif
        .id_pc(id_pc), .if_halt(if_halt3), .id_halt(id_halt3), .id_flush(id_flush3),
        .ex_flush(ex_flush3), .pc_sel(pc_sel3), .epc(epc3), .exc_cause(cause3),
        .in_exc(in_exc3)
    );

    function automatic stim_t mk(bit r, bit busy, bit br, bit ld, reg_addr_t rd,
                                 reg_addr_t ra, reg_addr_t rb, bit ub, bit sw, bit rf,
                                 bit er, addr_t pc);
        stim_t s;
        s = '{rst: r, mau_busy: busy, ex_branch: br, ex_load: ld, ex_regd: rd, rega: ra,
              regb: rb, uses_regb: ub, swi: sw, rfe: rf, id_err: er, irq: 1'b0, id_pc: pc};
        return s;
    endfunction

    function automatic obs_t ob(bit ih, bit dh, bit df, bit ef, pc_sel_t ps, addr_t e,
                                exc_cause_t c, bit ie);
        obs_t o;
        o = '{if_halt: ih, id_halt: dh, id_flush: df, ex_flush: ef, pc_sel: ps, epc: e,
              cause: c, in_exc: ie};
        return o;
    endfunction

    task automatic model(input int luc, input int efc, input mstate_t c, input stim_t s,
                         output obs_t e, output mstate_t n);
        bit hz;
        n = c;
        e = '0;
        if (s.rst) begin
            n = '{mem: 0, stall_left: 0, flush_left: 0, vec: 0, epc: '0, cause: ExcNone,
                  in_exc: 0};
            return;
        end
        e.epc = c.epc;
        e.cause = c.cause;
        e.in_exc = c.in_exc;
        hz = s.ex_load && (s.ex_regd != RF_PC) &&
             ((s.ex_regd == s.rega) || (s.uses_regb && (s.ex_regd == s.regb)));
        if (c.mem) begin
            e.if_halt = s.mau_busy;
            e.id_halt = s.mau_busy;
            n.mem = s.mau_busy;
        end else if (c.stall_left > 0) begin
            e.if_halt = 1; e.id_halt = 1; e.ex_flush = 1;
            n.stall_left = c.stall_left - 1;
        end else if (c.flush_left > 0) begin
            e.if_halt = 1; e.id_flush = 1;
            n.flush_left = c.flush_left - 1;
            n.vec = (n.flush_left == 0);
        end else if (c.vec) begin
            e.pc_sel = PcVector; e.id_flush = 1;
            n.vec = 0;
        end else if (s.mau_busy) begin
            e.if_halt = 1; e.id_halt = 1;
            n.mem = 1;
        end else if (s.id_err || s.swi || (IrqEn && s.irq && !c.in_exc)) begin
            e.if_halt = 1; e.id_flush = 1; e.ex_flush = 1;
            n.epc = s.id_pc;
            n.cause = s.id_err ? ExcErr : (s.swi ? ExcSwi : ExcIrq);
            n.in_exc = 1;
            n.flush_left = efc - 1;
            n.vec = (efc == 1);
        end else if (s.ex_branch) begin
            e.pc_sel = PcBranch; e.id_flush = 1;
        end else if (hz) begin
            e.if_halt = 1; e.id_halt = 1; e.ex_flush = 1;
            n.stall_left = luc - 1;
        end else if (s.rfe) begin
            e.pc_sel = PcEpc; e.id_flush = 1;
            n.in_exc = 0; n.cause = ExcNone;
        end
    endtask

    task automatic check(input string nm, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    // One clock: drive, sample at negedge, compare, advance model at posedge.
    task automatic cycle(input stim_t s, input bit use_tbl, input obs_t texp,
                         input string nm, output obs_t g1, output obs_t g3);
        obs_t e1, e3;
        mstate_t n1, n3;
        rst = s.rst; mau_busy = s.mau_busy; ex_branch = s.ex_branch; ex_load = s.ex_load;
        ex_regd = s.ex_regd; id_rega_addr = s.rega; id_regb_addr = s.regb;
        id_uses_regb = s.uses_regb; swi = s.swi; rfe = s.rfe; id_err = s.id_err;
        id_pc = s.id_pc;
`ifdef I2D_HAZARD_IRQ_EN
        irq = s.irq;
`endif
        model(1, 2, m1, s, e1, n1);
        model(3, 3, m3, s, e3, n3);
        @(negedge clk);
        g1 = o1;
        g3 = o3;
        check({nm, "_p1"}, o1, use_tbl ? texp : e1);
        check({nm, "_p3"}, o3, e3);
        @(posedge clk);
        m1 = n1;
        m3 = n3;
        #1;
    endtask

    initial begin
        obs_t g1, g3;
        stim_t s, idle;
        int cnt;
        bit seen;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Expectations for the LOAD_USE_CYCLES=1 / EXC_FLUSH_CYCLES=2 instance.
        tbl.push_back('{mk(1,0,0,0,0,0,0,0,1,0,0,0),      ob(0,0,0,0,PcSeq,0,ExcNone,0)});
        tbl.push_back('{mk(0,0,0,1,3,3,0,0,0,0,0,0),      ob(1,1,0,1,PcSeq,0,ExcNone,0)});
        tbl.push_back('{idle,                            ob(0,0,0,0,PcSeq,0,ExcNone,0)});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,1,0,0,'h100),  ob(1,0,1,1,PcSeq,0,ExcNone,0)});
        tbl.push_back('{idle,                       ob(1,0,1,0,PcSeq,'h100,ExcSwi,1)});
        tbl.push_back('{idle,                       ob(0,0,1,0,PcVector,'h100,ExcSwi,1)});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,1,0,0), ob(0,0,1,0,PcEpc,'h100,ExcSwi,1)});
        tbl.push_back('{idle,                       ob(0,0,0,0,PcSeq,'h100,ExcNone,0)});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{mk(0,1,1,0,0,0,0,0,0,0,0,0), ob(1,1,0,0,PcSeq,'h100,ExcNone,0)});
        tbl.push_back('{idle,                       ob(0,0,0,0,PcSeq,'h100,ExcNone,0)});
        tbl.push_back('{idle,                       ob(0,0,0,0,PcSeq,'h100,ExcNone,0)});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,1,0,1,'h200), ob(1,0,1,1,PcSeq,'h100,ExcNone,0)});
        tbl.push_back('{idle,                       ob(1,0,1,0,PcSeq,'h200,ExcErr,1)});
        tbl.push_back('{idle,                       ob(0,0,1,0,PcVector,'h200,ExcErr,1)});
        tbl.push_back('{mk(0,0,0,1,5,1,5,0,0,0,0,0), ob(0,0,0,0,PcSeq,'h200,ExcErr,1)});
        tbl.push_back('{mk(0,0,0,1,5,1,5,1,0,0,0,0), ob(1,1,0,1,PcSeq,'h200,ExcErr,1)});
        tbl.push_back('{mk(0,0,0,1,15,15,0,0,0,0,0,0), ob(0,0,0,0,PcSeq,'h200,ExcErr,1)});
        tbl.push_back('{mk(0,0,1,0,0,0,0,0,0,0,0,0), ob(0,0,1,0,PcBranch,'h200,ExcErr,1)});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,1,0,0,'h300), ob(1,0,1,1,PcSeq,'h200,ExcErr,1)});
        tbl.push_back('{mk(1,0,0,0,0,0,0,0,0,0,0,0), ob(0,0,0,0,PcSeq,0,ExcNone,0)});
        tbl.push_back('{idle,                       ob(0,0,0,0,PcSeq,0,ExcNone,0)});
        tbl.push_back('{mk(0,0,1,1,3,3,0,0,0,0,0,0), ob(0,0,1,0,PcBranch,0,ExcNone,0)});
        tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,1,0,0), ob(0,0,1,0,PcEpc,0,ExcNone,0)});

        rst = 1'b1;
        @(posedge clk);
        #1;
        foreach (tbl[i]) cycle(tbl[i].s, 1'b1, tbl[i].e, $sformatf("tbl%0d", i), g1, g3);

        // Load-use with three bubbles, hazard held while decode is stalled.
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, '0, "lu3_rst", g1, g3);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0,0,0,1,3,3,0,0,0,0,0,0), 1'b0, '0, "lu3_hz", g1, g3);
            if (g3.id_halt && g3.ex_flush) cnt++;
        end
        cycle(idle, 1'b0, '0, "lu3_end", g1, g3);
        if (g3.id_halt) cnt++;
        check_int("lu3_halt_cycles", cnt, 3);

        // Exception entry latency on the three-cycle flush instance.
        cycle(mk(0,0,0,0,0,0,0,0,1,0,0,'h140), 1'b0, '0, "ex3_swi", g1, g3);
        cnt = g3.if_halt ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(idle, 1'b0, '0, "ex3_wait", g1, g3);
            if (g3.pc_sel == PcVector) seen = 1'b1;
            else if (g3.if_halt) cnt++;
        end
        check_int("ex3_vector_seen", int'(seen), 1);
        check_int("ex3_flush_cycles", cnt, 3);
        check_int("ex3_epc", int'(g3.epc), 'h140);

`ifdef I2D_HAZARD_IRQ_EN
        s = idle;
        s.irq = 1'b1;
        cycle(s, 1'b0, '0, "irq_masked", g1, g3);
        check_int("irq_masked_flush", int'(g1.id_flush), 0);
        cycle(mk(0,0,0,0,0,0,0,0,0,1,0,0), 1'b0, '0, "irq_rfe", g1, g3);
        s.id_pc = 'h2c0;
        cycle(s, 1'b0, '0, "irq_take", g1, g3);
        cycle(idle, 1'b0, '0, "irq_after", g1, g3);
        check_int("irq_cause", int'(g1.cause), int'(ExcIrq));
        check_int("irq_epc", int'(g1.epc), 'h2c0);
`endif

        for (int i = 0; i < 3000; i++) begin
            s.rst       = ($urandom_range(0, 99) == 0);
            s.mau_busy  = ($urandom_range(0, 7) == 0);
            s.ex_branch = ($urandom_range(0, 7) == 0);
            s.ex_load   = ($urandom_range(0, 2) == 0);
            s.ex_regd   = ($urandom_range(0, 9) == 0) ? RF_PC : reg_addr_t'($urandom_range(0, 3));
            s.rega      = ($urandom_range(0, 9) == 0) ? RF_PC : reg_addr_t'($urandom_range(0, 3));
            s.regb      = reg_addr_t'($urandom_range(0, 3));
            s.uses_regb = $urandom_range(0, 1) == 1;
            s.swi       = ($urandom_range(0, 15) == 0);
            s.id_err    = ($urandom_range(0, 31) == 0);
            s.rfe       = ($urandom_range(0, 9) == 0);
            s.irq       = ($urandom_range(0, 9) == 0);
            s.id_pc     = addr_t'($urandom);
            cycle(s, 1'b0, '0, "rnd", g1, g3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
